// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared types and constants for the TD4 I/O checker
package td4_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_PASS = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    // Element i of a packed expected sequence lives in bits [4i+3:4i].
    function automatic nibble_t seq_nibble(input logic [31:0] seq, input logic [2:0] idx);
        return seq[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/td4_event_timer.sv
// rtl/td4_event_timer.sv - saturating inter-event cycle counter
module td4_event_timer
    import td4_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    // Holds at TIMEOUT-1 instead of wrapping; the checker leaves WAIT on that cycle anyway.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/td4_led_checker.sv
// rtl/td4_led_checker.sv - TD4 LED output sequence checker with per-event timeout
module td4_led_checker
    import td4_pkg::*;
#(
    parameter int          EXP_LEN  = 4,
    parameter logic [31:0] EXP_SEQ  = 32'h0000_8421,
    parameter int          TIMEOUT  = 64,
    parameter logic [3:0]  SW_VALUE = 4'b1010
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arm,
    input  nibble_t    led_in,
    output nibble_t    sw_out,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_code,
    output logic [3:0] match_cnt,
    output nibble_t    last_led
);

    localparam logic [2:0] LAST_IDX = 3'(EXP_LEN - 1);
    localparam logic [3:0] MAX_CNT  = 4'(EXP_LEN);

    state_t  state;
    logic [2:0] idx;
    logic    event_seen;
    logic    timer_clear;
    logic    timer_run;
    logic    timer_expired;
    nibble_t expected;

    assign event_seen  = (led_in != last_led);
    assign expected    = seq_nibble(EXP_SEQ, idx);
    assign timer_clear = (state != S_WAIT) || !arm || event_seen;
    assign timer_run   = !timer_clear;

    td4_event_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_out <= SW_VALUE;
        end else begin
            sw_out <= SW_VALUE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            match_cnt <= '0;
            last_led  <= '0;
        end else begin
            // The previous sample doubles as the baseline, so it tracks in every state.
            last_led <= led_in;
            case (state)
                S_IDLE: begin
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    fail      <= 1'b0;
                    fail_code <= FC_NONE;
                    match_cnt <= '0;
                    idx       <= '0;
                    if (arm) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!arm) begin
                        state     <= S_IDLE;
                        idx       <= '0;
                        match_cnt <= '0;
                        fail_code <= FC_NONE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                    end else if (event_seen) begin
                        if (led_in == expected) begin
                            if (match_cnt < MAX_CNT) begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                            idx <= idx + 3'd1;
                            if (idx == LAST_IDX) begin
                                state <= S_PASS;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end
                        end else begin
                            state     <= S_FAIL;
                            done      <= 1'b1;
                            fail      <= 1'b1;
                            fail_code <= FC_MISMATCH;
                        end
                    end else if (timer_expired) begin
                        state     <= S_FAIL;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                S_PASS, S_FAIL: begin
                    if (!arm) begin
                        state     <= S_IDLE;
                        idx       <= '0;
                        match_cnt <= '0;
                        fail_code <= FC_NONE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td4_led_checker.sv
// tb/tb_td4_led_checker.sv - directed self-checking bench for td4_led_checker
module tb_td4_led_checker;

    logic       clock;
    logic       reset;
    logic       arm;
    logic [3:0] led_in;
    logic [3:0] sw_out;
    logic       done;
    logic       pass;
    logic       fail;
    logic [1:0] fail_code;
    logic [3:0] match_cnt;
    logic [3:0] last_led;

    int n_cmp = 0;
    int n_err = 0;

    td4_led_checker dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .led_in    (led_in),
        .sw_out    (sw_out),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_code (fail_code),
        .match_cnt (match_cnt),
        .last_led  (last_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic flags(input string tag, input logic d, input logic p, input logic f,
                         input logic [1:0] fc, input logic [3:0] mc);
        check_val({tag, ".done"}, 32'(done), 32'(d));
        check_val({tag, ".pass"}, 32'(pass), 32'(p));
        check_val({tag, ".fail"}, 32'(fail), 32'(f));
        check_val({tag, ".code"}, 32'(fail_code), 32'(fc));
        check_val({tag, ".cnt"},  32'(match_cnt), 32'(mc));
    endtask

    // Leaves the checker in IDLE with led_in=0, then arms with baseline 0.
    task automatic rearm();
        arm    = 1'b0;
        led_in = 4'h0;
        tick(2);
        arm = 1'b1;
        tick(1);
    endtask

    initial begin
        reset  = 1'b1;
        arm    = 1'b0;
        led_in = 4'h0;
        tick(3);
        flags("reset", 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        check_val("reset.sw", 32'(sw_out), 32'hA);
        check_val("reset.last", 32'(last_led), 32'h0);
        reset = 1'b0;
        tick(2);
        check_val("idle.sw", 32'(sw_out), 32'hA);

        // full matching sequence
        arm = 1'b1;
        tick(1);
        led_in = 4'h1; tick(10);
        led_in = 4'h2; tick(1);
        check_val("seq.mid_cnt", 32'(match_cnt), 32'd2);
        tick(9);
        led_in = 4'h4; tick(10);
        check_val("seq.not_done", 32'(done), 32'd0);
        led_in = 4'h8; tick(1);
        flags("seq", 1'b1, 1'b1, 1'b0, 2'b00, 4'd4);
        check_val("seq.last", 32'(last_led), 32'h8);
        tick(100);
        flags("seq_sticky", 1'b1, 1'b1, 1'b0, 2'b00, 4'd4);

        // mismatch 1 -> 3
        rearm();
        led_in = 4'h1; tick(1);
        led_in = 4'h3; tick(1);
        flags("mism", 1'b1, 1'b0, 1'b1, 2'b01, 4'd1);
        check_val("mism.last", 32'(last_led), 32'h3);

        // timeout exactly 64 edges after the 1 is captured
        rearm();
        led_in = 4'h1; tick(1);
        tick(63);
        check_val("tmo.early", 32'(fail), 32'd0);
        tick(1);
        flags("tmo", 1'b1, 1'b0, 1'b1, 2'b10, 4'd1);

        // event on edge 64 beats the timeout
        rearm();
        led_in = 4'h1; tick(1);
        tick(63);
        led_in = 4'h2; tick(1);
        flags("race", 1'b0, 1'b0, 1'b0, 2'b00, 4'd2);

        // abort after 1->2, then rerun from baseline 2
        rearm();
        led_in = 4'h1; tick(1);
        led_in = 4'h2; tick(1);
        arm = 1'b0; tick(1);
        flags("abort", 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        arm = 1'b1; tick(1);
        led_in = 4'h1; tick(3);
        led_in = 4'h2; tick(3);
        led_in = 4'h4; tick(3);
        led_in = 4'h8; tick(1);
        flags("rerun", 1'b1, 1'b1, 1'b0, 2'b00, 4'd4);

        // abort in the same cycle as the completing event
        rearm();
        led_in = 4'h1; tick(1);
        led_in = 4'h2; tick(1);
        led_in = 4'h4; tick(1);
        led_in = 4'h8; arm = 1'b0; tick(1);
        flags("abort_wins", 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);

        // asynchronous reset mid-WAIT
        rearm();
        led_in = 4'h1; tick(1);
        led_in = 4'h2; tick(1);
        check_val("areset.pre_cnt", 32'(match_cnt), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_val("areset.cnt", 32'(match_cnt), 32'd0);
        check_val("areset.last", 32'(last_led), 32'h0);
        arm = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(70);
        flags("post_reset", 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        arm = 1'b1; tick(1);
        led_in = 4'h1; tick(1);
        check_val("rearmed.cnt", 32'(match_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
